hicore_de2issue_pipe: RTL

- Transmitting end of the de2issue pipe interface.
- Sits between the decoder and the issue stage.
- Buffers decoded instructions in a 2-entry FIFO and stamps each one with a sequentially allocated ROB pointer.
- Drives the valid/ready/cancel/info handshake that the issue stage consumes; flush kills all in-flight entries and reloads the ROB pointer.

---
 rtl/hicore_de2issue_pipe.sv | 85 ++++++++
 1 files changed

// File: rtl/hicore_de2issue_pipe.sv
// hicore_de2issue_pipe: transmitting end of the decode-to-issue interface.
// Two-entry FIFO between decoder and issue stage. Each accepted instruction
// is stamped with the next sequential ROB pointer. Flush kills both entries
// and reloads the allocation pointer from the committing branch/exception.
module hicore_de2issue_pipe #(
  parameter int PAYLOAD_W = 112,
  parameter int ROB_PTR_W = 4,
  parameter int SEL_W     = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_dec_valid,
  output logic                                 o_dec_ready,
  input  logic [SEL_W-1:0]                     i_dec_sel,
  input  logic [PAYLOAD_W-1:0]                 i_dec_payload,
  input  logic                                 i_rob_full,
  input  logic                                 i_flush,
  input  logic [ROB_PTR_W-1:0]                 i_flush_rob_ptr,
  output logic                                 o_de2issue_valid,
  input  logic                                 i_de2issue_ready,
  output logic                                 o_de2issue_cancel,
  output logic [SEL_W+ROB_PTR_W+PAYLOAD_W-1:0] o_de2issue_info
);

  localparam int ENTRY_W = SEL_W + ROB_PTR_W + PAYLOAD_W;

  // Entry storage, indexed by the 1-bit read/write pointers.
  logic [ENTRY_W-1:0]   entry_q [2];
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [1:0]           count;
  logic [ROB_PTR_W-1:0] alloc_ptr;

  logic                 push;
  logic                 pop;
  logic                 not_full;

  // Handshake decode; ready deliberately ignores i_dec_valid so the decoder
  // never sees a combinational loop through valid->ready.
  always_comb begin
    not_full          = (count != 2'd2);
    o_dec_ready       = not_full & ~i_rob_full & ~i_flush;
    push              = i_dec_valid & o_dec_ready;
    o_de2issue_valid  = (count != 2'd0);
    pop               = o_de2issue_valid & i_de2issue_ready & ~i_flush;
    o_de2issue_cancel = i_flush;
    o_de2issue_info   = '0;
    if (count != 2'd0) begin
      o_de2issue_info = entry_q[rd_ptr];
    end
  end

  // FIFO state, entry writes and ROB pointer allocation. Reset beats flush;
  // flush beats any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      alloc_ptr  <= '0;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else if (i_flush) begin
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      alloc_ptr <= i_flush_rob_ptr;
    end else begin
      if (push) begin
        entry_q[wr_ptr] <= {i_dec_sel, alloc_ptr, i_dec_payload};
        wr_ptr          <= ~wr_ptr;
        alloc_ptr       <= alloc_ptr + ROB_PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
